// File: rtl/perm_rot_sched_pkg.sv
// Shared types, defaults and helpers for the slice-rotation scheduler.
// Optional per-slice skew is enabled with the PERM_SKEW_EN macro.
package perm_pkg;

    localparam int SLICES_DEF = 16;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Width of one slice address; never narrower than one bit.
    function automatic int addr_w(input int slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage

// File: rtl/perm_rot_sched_if.sv
// Command/data/address-vector handshake bundle for perm_rot_sched.
// The cmd_skew field exists only when PERM_SKEW_EN is defined.
interface perm_rot_sched_if
    import perm_pkg::*;
#(
    parameter int SLICES = SLICES_DEF,
    parameter int ADDR_W = addr_w(SLICES),
    parameter int CNT_W  = CNT_W_DEF
);

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [ADDR_W-1:0]        cmd_shift;
    logic [ADDR_W-1:0]        cmd_step;
    logic [CNT_W-1:0]         cmd_beats;
`ifdef PERM_SKEW_EN
    logic [ADDR_W-1:0]        cmd_skew;
`endif
    logic                     dat_valid;
    logic                     dat_ready;
    logic                     perm_valid;
    logic                     perm_ready;
    logic [SLICES*ADDR_W-1:0] t_addr_dat;
    logic                     perm_last;
    logic                     busy;

    // The scheduler side.
    modport slave (
        input  cmd_valid, cmd_shift, cmd_step, cmd_beats,
`ifdef PERM_SKEW_EN
        input  cmd_skew,
`endif
        input  dat_valid, perm_ready,
        output cmd_ready, dat_ready, perm_valid, t_addr_dat, perm_last, busy
    );

    // The command/data source and address consumer side.
    modport master (
        output cmd_valid, cmd_shift, cmd_step, cmd_beats,
`ifdef PERM_SKEW_EN
        output cmd_skew,
`endif
        output dat_valid, perm_ready,
        input  cmd_ready, dat_ready, perm_valid, t_addr_dat, perm_last, busy
    );

endinterface

// File: rtl/perm_rot_sched_addr_gen.sv
// Combinational expansion of a base rotation into one address per slice.
// With PERM_SKEW_EN, slice s gets base + s*skew; otherwise every slice gets base.
module perm_addr_gen
    import perm_pkg::*;
#(
    parameter int SLICES = SLICES_DEF,
    parameter int ADDR_W = addr_w(SLICES)
) (
    input  logic [ADDR_W-1:0]        base_i,
`ifdef PERM_SKEW_EN
    input  logic [ADDR_W-1:0]        skew_i,
`endif
    output logic [SLICES*ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] skew;

`ifdef PERM_SKEW_EN
    assign skew = skew_i;
`else
    assign skew = '0;
`endif

    // Truncation to ADDR_W bits is the modulo-SLICES wrap.
    for (genvar s = 0; s < SLICES; s++) begin : g_slice
        localparam logic [ADDR_W-1:0] SIDX = ADDR_W'(s);
        assign addr_o[s*ADDR_W +: ADDR_W] = base_i + SIDX * skew;
    end

endmodule

// File: rtl/perm_rot_sched.sv
// Rotation command scheduler: turns each command into one slice-address vector per data beat.
// Optional per-slice skew is enabled with the PERM_SKEW_EN macro.
module perm_rot_sched
    import perm_pkg::*;
#(
    parameter int SLICES = SLICES_DEF,
    parameter int ADDR_W = addr_w(SLICES),
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    perm_rot_sched_if.slave  bus
);

    state_e                   state_q;
    logic [ADDR_W-1:0]        cur_shift_q;
    logic [ADDR_W-1:0]        cur_shift_d;
    logic [ADDR_W-1:0]        step_q;
    logic [CNT_W-1:0]         remain_q;
    logic [CNT_W-1:0]         remain_d;
`ifdef PERM_SKEW_EN
    logic [ADDR_W-1:0]        skew_q;
`endif
    logic                     perm_valid_q;
    logic                     perm_last_q;
    logic [SLICES*ADDR_W-1:0] addr_q;
    logic [SLICES*ADDR_W-1:0] addr_vec;

    logic                     dat_ready;
    logic                     cmd_fire;
    logic                     beat_fire;
    logic                     last_beat;

    // A single output register: a new beat is taken only if the slot is empty or draining.
    assign dat_ready   = (state_q == RUN) && (!perm_valid_q || bus.perm_ready);
    assign cmd_fire    = (state_q == IDLE) && bus.cmd_valid;
    assign beat_fire   = dat_ready && bus.dat_valid;
    assign last_beat   = (remain_q == CNT_W'(1));
    assign cur_shift_d = cur_shift_q + step_q;
    assign remain_d    = remain_q - CNT_W'(1);

    perm_addr_gen #(
        .SLICES (SLICES),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .base_i (cur_shift_q),
`ifdef PERM_SKEW_EN
        .skew_i (skew_q),
`endif
        .addr_o (addr_vec)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cur_shift_q  <= '0;
            step_q       <= '0;
            remain_q     <= '0;
`ifdef PERM_SKEW_EN
            skew_q       <= '0;
`endif
            perm_valid_q <= 1'b0;
            perm_last_q  <= 1'b0;
            addr_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A zero-beat command is consumed without leaving IDLE.
                    if (cmd_fire && (bus.cmd_beats != '0)) begin
                        cur_shift_q <= bus.cmd_shift;
                        step_q      <= bus.cmd_step;
                        remain_q    <= bus.cmd_beats;
`ifdef PERM_SKEW_EN
                        skew_q      <= bus.cmd_skew;
`endif
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (beat_fire) begin
                        cur_shift_q <= cur_shift_d;
                        remain_q    <= remain_d;
                        if (last_beat) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (beat_fire) begin
                perm_valid_q <= 1'b1;
                perm_last_q  <= last_beat;
                addr_q       <= addr_vec;
            end else if (bus.perm_ready) begin
                perm_valid_q <= 1'b0;
                perm_last_q  <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.dat_ready  = dat_ready;
    assign bus.perm_valid = perm_valid_q;
    assign bus.perm_last  = perm_last_q;
    assign bus.t_addr_dat = addr_q;
    assign bus.busy       = (state_q != IDLE) || perm_valid_q;

endmodule

// File: tb/tb_perm_rot_sched.sv
// Self-checking bench for perm_rot_sched: directed cases plus randomized traffic
// against a queue-based model of the expected address vectors.
module tb_perm_rot_sched;

    localparam int SL = 16;
    localparam int AW = 4;
    localparam int CW = 8;
    localparam int VW = SL * AW;

    typedef struct {
        logic [VW-1:0] vec;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic reset_n;

    perm_rot_sched_if #(.SLICES(SL), .ADDR_W(AW), .CNT_W(CW)) bus ();

    perm_rot_sched #(.SLICES(SL), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int      compared   = 0;
    int      mismatched = 0;
    beat_t   expQ[$];
    int      pending    = 0;
    int      inflight   = 0;
    int      datCount   = 0;
    logic    cv, dv, pr, randMode, accepted;
    logic [AW-1:0] cs, cst, csk;
    logic [CW-1:0] cb;

    task automatic checkOutput(input string tag, input logic [VW-1:0] observed,
                               input logic [VW-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [VW-1:0] expVec(input int rot, input int skew);
        logic [VW-1:0] v;
        v = '0;
        for (int s = 0; s < SL; s++) begin
            v[s*AW +: AW] = AW'((rot + s * skew) % SL);
        end
        return v;
    endfunction

    // Every beat of an accepted command, in the order the network must see them.
    task automatic pushCommand(input int shift, input int step, input int beats, input int skew);
        beat_t b;
        for (int k = 0; k < beats; k++) begin
            b.vec  = expVec((shift + k * step) % SL, skew);
            b.last = (k == beats - 1);
            expQ.push_back(b);
        end
    endtask

    // One clock: drive at negedge, check, then advance the model past the coming posedge.
    task automatic applyStimulus();
        bit outFire, datFire, cmdFire;
        @(negedge clk);
        if (randMode) begin
            dv = ($urandom_range(0, 3) != 0);
            pr = ($urandom_range(0, 9) < 7);
        end
        bus.cmd_valid  = cv;
        bus.cmd_shift  = cs;
        bus.cmd_step   = cst;
        bus.cmd_beats  = cb;
`ifdef PERM_SKEW_EN
        bus.cmd_skew   = csk;
`endif
        bus.dat_valid  = dv;
        bus.perm_ready = pr;
        #1;
        checkOutput("cmd_ready", bus.cmd_ready, pending == 0);
        checkOutput("perm_valid", bus.perm_valid, inflight != 0);
        checkOutput("busy", bus.busy, (pending != 0) || (inflight != 0));
        if (pending == 0)
            checkOutput("dat_ready_idle", bus.dat_ready, 1'b0);
        else
            checkOutput("dat_ready_run", bus.dat_ready, (inflight == 0) || pr);
        if (bus.perm_valid && expQ.size() != 0) begin
            checkOutput("t_addr_dat", bus.t_addr_dat, expQ[0].vec);
            checkOutput("perm_last", bus.perm_last, expQ[0].last);
        end

        outFire = (inflight != 0) && pr;
        datFire = (pending != 0) && dv && ((inflight == 0) || pr);
        cmdFire = (pending == 0) && cv;
        accepted = cmdFire;
        if (outFire) begin
            void'(expQ.pop_front());
            inflight--;
        end
        if (datFire) begin
            pending--;
            inflight++;
            datCount++;
        end
        if (cmdFire && cb != '0) begin
            pending = int'(cb);
`ifdef PERM_SKEW_EN
            pushCommand(int'(cs), int'(cst), int'(cb), int'(csk));
`else
            pushCommand(int'(cs), int'(cst), int'(cb), 0);
`endif
        end
    endtask

    task automatic issueCommand(input int shift, input int step, input int beats,
                                input int skew, output int waitCycles);
        cs  = AW'(shift);
        cst = AW'(step);
        cb  = CW'(beats);
        csk = AW'(skew);
        cv  = 1'b1;
        waitCycles = 0;
        do begin
            applyStimulus();
            waitCycles++;
        end while (!accepted && waitCycles < 1000);
        cv = 1'b0;
        checkOutput("cmd_accept_timeout", accepted, 1'b1);
    endtask

    task automatic drainAll(input int budget, output int n);
        n = 0;
        while ((pending != 0 || inflight != 0) && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput("drain_done", (pending == 0) && (inflight == 0), 1'b1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
        checkOutput({tag, "_dat_ready"}, bus.dat_ready, 1'b0);
        checkOutput({tag, "_perm_valid"}, bus.perm_valid, 1'b0);
        checkOutput({tag, "_perm_last"}, bus.perm_last, 1'b0);
        checkOutput({tag, "_t_addr_dat"}, bus.t_addr_dat, '0);
        checkOutput({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        int w, n, start;
        cv = 0; dv = 0; pr = 0; randMode = 0; accepted = 0;
        cs = '0; cst = '0; cb = '0; csk = '0;
        bus.cmd_valid = 0; bus.cmd_shift = '0; bus.cmd_step = '0; bus.cmd_beats = '0;
`ifdef PERM_SKEW_EN
        bus.cmd_skew = '0;
`endif
        bus.dat_valid = 0; bus.perm_ready = 0;
        reset_n = 1'b0;
        #2;
        checkResetState("reset");
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Single command, full throughput: 3,4,5,6 with last on the fourth.
        dv = 1; pr = 1;
        issueCommand(3, 1, 4, 0, w);
        drainAll(100, n);
        checkOutput("single_cycles", n, 5);

        // Wrap-around: 14,1,4.
        issueCommand(14, 3, 3, 0, w);
        drainAll(100, n);

        // Backpressure in the middle of an 8-beat command.
        issueCommand(5, 2, 8, 0, w);
        repeat (3) applyStimulus();
        pr = 0;
        repeat (5) applyStimulus();
        pr = 1;
        drainAll(100, n);

        // Zero-beat command, then a real one accepted on the very next cycle.
        issueCommand(9, 9, 0, 0, w);
        checkOutput("zero_accept_wait", w, 1);
        issueCommand(7, 1, 2, 0, w);
        checkOutput("after_zero_accept_wait", w, 1);
        drainAll(100, n);

        // Reset after beat 2 of 8 aborts the command.
        issueCommand(0, 1, 8, 0, w);
        start = datCount;
        n = 0;
        while (datCount - start < 2 && n < 50) begin
            applyStimulus();
            n++;
        end
        checkOutput("mid_beats_reached", datCount - start, 2);
        @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        checkResetState("midreset");
        expQ.delete();
        pending = 0;
        inflight = 0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        issueCommand(9, 5, 3, 0, w);
        drainAll(100, n);

        // Longest command with a constant rotation.
        issueCommand(11, 0, 255, 0, w);
        drainAll(600, n);
        checkOutput("max_beats_cycles", n, 256);

`ifdef PERM_SKEW_EN
        issueCommand(0, 0, 1, 1, w);
        drainAll(100, n);
`endif

        // Randomized traffic with random data availability and backpressure.
        randMode = 1;
        for (int i = 0; i < 30; i++) begin
            int beats;
            beats = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
            issueCommand(int'($urandom_range(0, SL - 1)), int'($urandom_range(0, SL - 1)),
                         beats, int'($urandom_range(0, SL - 1)), w);
        end
        drainAll(2000, n);
        randMode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
